demux_tdm_tree: RTL
===================

# demux_tdm_tree

Pipelined 1-to-8 time-division demultiplexer, the receive-side counterpart of the 8:1 tree multiplexer. A serial stream of WIDTH-bit samples arrives one per valid cycle. A slot counter assigns each sample to channel 0..7, and a three-level registered tree of 1:2 demux stages steers it to that channel's output register. Used wherever eight sources were time-multiplexed onto one lane and must be fanned back out with per-channel strobes and frame alignment.

## Interface
- WIDTH, 1, bits per sample and per channel
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- inp  input  WIDTH  serial sample in
- inValid  input  1  inp carries a sample this cycle
- frameSync  input  1  force the current sample (or next slot) to channel 0
- outp  output  8*WIDTH  channel registers; channel k at [k*WIDTH +: WIDTH]
- outValid  output  8  one-hot pulse: channel k updated this cycle
- frameDone  output  1  pulse: channel 7 written this cycle
- frameErr  output  1  pulse: frameSync received with slot counter ≠ 0
- slot  output  3  current slot counter value (next channel to be assigned)

## Operation
- Reset behaviour: the cycle after rst=1, every output is 0 (outp, outValid, frameDone, frameErr, slot), and all pipeline valid bits are cleared.
- Channel assignment, each cycle:
  - ch = frameSync ? 0 : slot.
  - If inValid, the sample is accepted with channel ch, and slot ← (ch+1) mod 8.
  - If frameSync=1 and inValid=0, slot ← 0 and no sample is accepted.
  - Wrap-around: after slot 7, the counter returns to 0.
- frameErr: registered pulse the cycle after any frameSync=1 seen while slot≠0. The sync still takes effect. A partial frame is abandoned; the earlier channels keep their values.
- Pipeline: three stages, each holding {valid, data, remaining select bits}. The select ordering is the mirror of the mux tree.
  - S1 splits on ch[2].
  - S2 splits on ch[1].
  - S3 splits on ch[0] and writes the channel register.
  - Each stage's valid follows the previous stage unconditionally. There is no backpressure: throughput is 1 sample per cycle.
- Channel write: when S3 is valid with channel k:
  - outp[k] ← data.
  - outValid ← one-hot(k); all other bits 0.
  - frameDone = (k==7).
  - Channels not written hold their value indefinitely.
- Ordering: samples leave in acceptance order. There is no reordering and no drop while rst=0.
- Reset mid-operation: in-flight samples are discarded, outp clears to 0, and no strobe fires for discarded samples.

## Timing
- Latency: a sample accepted at edge N (inValid sampled high) appears on outp with its outValid bit high after edge N+3, i.e. visible during cycle N+3.
- Strobes:
  - outValid and frameDone are single-cycle pulses, coincident with the outp update.
  - frameErr is independent of the data pipeline and fires 1 cycle after the offending sync.
- slot is registered. It reflects the acceptances up to and including the previous edge.
- Simultaneous rst with inValid/frameSync: rst wins and the sample is not accepted.
- All outputs are registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset check: assert rst 2 cycles, then release.
  - Required: outp=0, outValid=0, frameDone=0, frameErr=0, slot=0.
  - Hold inValid=0 for 10 cycles; all outputs stay 0.
- Full frame (WIDTH=4): frameSync=1 with the first sample, then 8 consecutive valid samples 0xA,0x1,…,0x7.
  - Required: outValid walks 0x01..0x80 on cycles 3..10 after the first acceptance.
  - Required: final outp=0x7654321A.
  - Required: frameDone high only on the cycle of outValid=0x80.
- Gapped input: samples with inValid toggling 1,0,0,1,…
  - Required: each outValid pulse arrives exactly 3 cycles after its own acceptance.
  - Required: slot increments only on accepted cycles and wraps from 7 to 0.
- Early resync: accept 3 samples (slot=3), then frameSync=1 with inValid=1 and data 0xF.
  - Required: frameErr pulses 1 cycle later.
  - Required: 0xF lands in channel 0 at +3, and slot=1.
  - Required: channels 1,2 retain their prior values.
- Sync without data: slot=5, then frameSync=1 with inValid=0.
  - Required: slot=0 and frameErr pulses.
  - Required: no outValid pulse and outp unchanged.
- Reset in flight: accept 2 samples, assert rst on the next cycle.
  - Required: no outValid pulse ever fires for those samples, outp=0, slot=0.
  - Required: the next frame after release behaves as in the full-frame scenario.

Source files
------------

// File: rtl/demux_tdm_tree.sv
// Pipelined 1-to-8 time-division demultiplexer: a slot counter tags each accepted
// sample with its channel, then a three-level registered 1:2 tree steers it to that channel.
module demux_tdm_tree #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   inp,
  input  logic               inValid,
  input  logic               frameSync,
  output logic [8*WIDTH-1:0] outp,
  output logic [7:0]         outValid,
  output logic               frameDone,
  output logic               frameErr,
  output logic [2:0]         slot
);

  logic [2:0]       slot_q, slot_d;
  logic [2:0]       ch_s;
  logic             frame_err_d;

  logic             in_v_q, in_v_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic [2:0]       in_ch_q, in_ch_d;

  logic [1:0]       s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_data_q [2];
  logic [WIDTH-1:0] s1_data_d [2];
  logic [1:0]       s1_sel_q [2];
  logic [1:0]       s1_sel_d [2];

  logic [3:0]       s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_data_q [4];
  logic [WIDTH-1:0] s2_data_d [4];
  logic [3:0]       s2_sel_q, s2_sel_d;

  logic [WIDTH-1:0] chan_q [8];
  logic [WIDTH-1:0] chan_d [8];
  logic [7:0]       out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q;

  // Slot assignment: a sync forces channel 0; a sync without data just rewinds the counter.
  always_comb begin
    ch_s        = frameSync ? 3'd0 : slot_q;
    frame_err_d = frameSync && (slot_q != 3'd0);
    in_v_d      = inValid;
    in_ch_d     = ch_s;
    if (inValid) begin
      slot_d    = ch_s + 3'd1;
      in_data_d = inp;
    end else if (frameSync) begin
      slot_d    = 3'd0;
      in_data_d = in_data_q;
    end else begin
      slot_d    = slot_q;
      in_data_d = in_data_q;
    end
  end

  // Tree level 1 splits on ch[2]; data only moves into a branch that becomes valid.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      s1_v_d[j]    = 1'b0;
      s1_data_d[j] = s1_data_q[j];
      s1_sel_d[j]  = s1_sel_q[j];
      if (in_v_q && (in_ch_q[2] == j[0])) begin
        s1_v_d[j]    = 1'b1;
        s1_data_d[j] = in_data_q;
        s1_sel_d[j]  = in_ch_q[1:0];
      end else begin
        s1_v_d[j]    = 1'b0;
      end
    end
  end

  // Tree level 2 splits on ch[1].
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      s2_v_d[j]    = 1'b0;
      s2_data_d[j] = s2_data_q[j];
      s2_sel_d[j]  = s2_sel_q[j];
      if (s1_v_q[j/2] && (s1_sel_q[j/2][1] == j[0])) begin
        s2_v_d[j]    = 1'b1;
        s2_data_d[j] = s1_data_q[j/2];
        s2_sel_d[j]  = s1_sel_q[j/2][0];
      end else begin
        s2_v_d[j]    = 1'b0;
      end
    end
  end

  // Tree level 3 splits on ch[0] and updates the addressed channel register plus strobes.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      chan_d[k]      = chan_q[k];
      out_valid_d[k] = 1'b0;
      if (s2_v_q[k/2] && (s2_sel_q[k/2] == k[0])) begin
        chan_d[k]      = s2_data_q[k/2];
        out_valid_d[k] = 1'b1;
      end else begin
        out_valid_d[k] = 1'b0;
      end
    end
    frame_done_d = out_valid_d[7];
  end

  // State registers; reset discards in-flight samples and clears every channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= 3'd0;
      in_v_q       <= 1'b0;
      in_data_q    <= '0;
      in_ch_q      <= 3'd0;
      s1_v_q       <= 2'b00;
      s2_v_q       <= 4'b0000;
      s2_sel_q     <= 4'b0000;
      out_valid_q  <= 8'h00;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int j = 0; j < 2; j++) begin
        s1_data_q[j] <= '0;
        s1_sel_q[j]  <= 2'b00;
      end
      for (int j = 0; j < 4; j++) begin
        s2_data_q[j] <= '0;
      end
      for (int k = 0; k < 8; k++) begin
        chan_q[k] <= '0;
      end
    end else begin
      slot_q       <= slot_d;
      in_v_q       <= in_v_d;
      in_data_q    <= in_data_d;
      in_ch_q      <= in_ch_d;
      s1_v_q       <= s1_v_d;
      s2_v_q       <= s2_v_d;
      s2_sel_q     <= s2_sel_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      for (int j = 0; j < 2; j++) begin
        s1_data_q[j] <= s1_data_d[j];
        s1_sel_q[j]  <= s1_sel_d[j];
      end
      for (int j = 0; j < 4; j++) begin
        s2_data_q[j] <= s2_data_d[j];
      end
      for (int k = 0; k < 8; k++) begin
        chan_q[k] <= chan_d[k];
      end
    end
  end

  // Pack channel registers onto the flat output bus.
  always_comb begin
    outp = '0;
    for (int k = 0; k < 8; k++) begin
      outp[k*WIDTH +: WIDTH] = chan_q[k];
    end
  end

  assign outValid  = out_valid_q;
  assign frameDone = frame_done_q;
  assign frameErr  = frame_err_q;
  assign slot      = slot_q;

endmodule
